rgb_pwm_fader: RTL and testbench

RGB_PWM_FADER -- requirements
Module: rgb_pwm_fader

---
 rtl/rgb_pwm_fader.sv | 94 +++++++++
 tb/tb_rgb_pwm_fader.sv | 173 +++++++++++++++++
 2 files changed

// File: rtl/rgb_pwm_fader.sv
// Three-channel LED fader: each colour ramps its level toward full or off, and a shared
// PWM counter turns the levels into active-low pin waveforms with period-aligned duty updates.
module rgb_pwm_fader #(
    parameter int PWM_BITS = 8,
    parameter int RAMP_DIV = 12000,
    parameter int STEP     = 1
) (
    input  logic clk,
    input  logic rst,
    input  logic red,
    input  logic green,
    input  logic blue,
    output logic RGB_R,
    output logic RGB_G,
    output logic RGB_B,
    output logic settled
);
    localparam int RW = $clog2(RAMP_DIV);
    localparam logic [PWM_BITS-1:0] MAX       = '1;
    localparam logic [RW-1:0]       RAMP_LAST = RW'(RAMP_DIV - 1);
    localparam logic [PWM_BITS:0]   STEP_X    = (PWM_BITS + 1)'(STEP);

    typedef enum logic [1:0] {HOLD, RISE, FALL} ch_state_e;

    logic [2:0]                tgt_q, tgt_d;
    logic [RW-1:0]             ramp_cnt_q, ramp_cnt_d;
    logic                      tick;
    ch_state_e                 state_q [3];
    ch_state_e                 state_d [3];
    logic [2:0][PWM_BITS-1:0]  level_q, level_d;
    logic [2:0][PWM_BITS-1:0]  duty_q, duty_d;
    logic [2:0][PWM_BITS-1:0]  tgt_lvl;
    logic [2:0][PWM_BITS:0]    sum, diff;
    logic [PWM_BITS-1:0]       pwm_cnt_q, pwm_cnt_d;
    logic [2:0]                pin_q, pin_d;
    logic                      settled_q, settled_d;

    always_comb begin
        tgt_d      = {blue, green, red};
        tick       = (ramp_cnt_q == RAMP_LAST);
        ramp_cnt_d = tick ? '0 : ramp_cnt_q + 1'b1;
        pwm_cnt_d  = pwm_cnt_q + 1'b1;
        settled_d  = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tgt_lvl[i] = tgt_q[i] ? MAX : '0;
            sum[i]     = {1'b0, level_q[i]} + STEP_X;
            // A negative difference wraps into the extra top bit, which flags underflow.
            diff[i]    = {1'b0, level_q[i]} - STEP_X;

            if (level_q[i] < tgt_lvl[i])      state_d[i] = RISE;
            else if (level_q[i] > tgt_lvl[i]) state_d[i] = FALL;
            else                              state_d[i] = HOLD;

            // The tick acts on the direction registered before this edge.
            level_d[i] = level_q[i];
            if (tick && state_q[i] == RISE)
                level_d[i] = (sum[i] > {1'b0, tgt_lvl[i]}) ? tgt_lvl[i] : sum[i][PWM_BITS-1:0];
            else if (tick && state_q[i] == FALL)
                level_d[i] = (diff[i][PWM_BITS] || diff[i][PWM_BITS-1:0] < tgt_lvl[i])
                             ? tgt_lvl[i] : diff[i][PWM_BITS-1:0];

            duty_d[i] = (pwm_cnt_q == MAX) ? level_q[i] : duty_q[i];
            pin_d[i]  = ~((duty_q[i] == MAX) || (pwm_cnt_q < duty_q[i]));
            if (state_q[i] != HOLD) settled_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            tgt_q      <= '0;
            ramp_cnt_q <= '0;
            pwm_cnt_q  <= '0;
            level_q    <= '0;
            duty_q     <= '0;
            pin_q      <= '1;
            settled_q  <= 1'b1;
            for (int i = 0; i < 3; i++) state_q[i] <= HOLD;
        end else begin
            tgt_q      <= tgt_d;
            ramp_cnt_q <= ramp_cnt_d;
            pwm_cnt_q  <= pwm_cnt_d;
            level_q    <= level_d;
            duty_q     <= duty_d;
            pin_q      <= pin_d;
            settled_q  <= settled_d;
            for (int i = 0; i < 3; i++) state_q[i] <= state_d[i];
        end
    end

    assign RGB_R   = pin_q[0];
    assign RGB_G   = pin_q[1];
    assign RGB_B   = pin_q[2];
    assign settled = settled_q;
endmodule

// File: tb/tb_rgb_pwm_fader.sv
// Bench for rgb_pwm_fader: a fast-ramp instance for ramp, reversal and reset behaviour,
// and a slow-ramp instance whose ticks land mid-period for PWM duty and shadow checks.
module tb_rgb_pwm_fader;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst, red, green, blue, rgb_r, rgb_g, rgb_b, settled;
    logic rst2, red2, green2, blue2, rgb_r2, rgb_g2, rgb_b2, settled2;

    rgb_pwm_fader #(.PWM_BITS(8), .RAMP_DIV(4), .STEP(64)) dut (
        .clk(clk), .rst(rst), .red(red), .green(green), .blue(blue),
        .RGB_R(rgb_r), .RGB_G(rgb_g), .RGB_B(rgb_b), .settled(settled));

    rgb_pwm_fader #(.PWM_BITS(8), .RAMP_DIV(357), .STEP(64)) dut2 (
        .clk(clk), .rst(rst2), .red(red2), .green(green2), .blue(blue2),
        .RGB_R(rgb_r2), .RGB_G(rgb_g2), .RGB_B(rgb_b2), .settled(settled2));

    int n_vec  = 0;
    int n_fail = 0;

    typedef struct {
        string       name;
        int          sel;
        logic [31:0] exp;
    } exp_t;
    exp_t sb_q[$];

    typedef struct {
        logic       rst, r, g, b;
        logic [2:0] pins;
        logic       st;
        logic [7:0] lr, lb;
    } vec_t;
    vec_t vt[47];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    function automatic logic [31:0] actual(input int sel);
        case (sel)
            0:       return {29'b0, rgb_r, rgb_g, rgb_b};
            1:       return {31'b0, settled};
            2:       return {24'b0, dut.level_q[0]};
            3:       return {24'b0, dut.level_q[2]};
            default: return {24'b0, dut.pwm_cnt_q};
        endcase
    endfunction

    task automatic push(input string name, input int sel, input logic [31:0] exp);
        exp_t e;
        e.name = name; e.sel = sel; e.exp = exp;
        sb_q.push_back(e);
    endtask

    task automatic step_drain();
        exp_t e;
        @(posedge clk);
        #1;
        while (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            chk(e.name, actual(e.sel), e.exp);
        end
    endtask

    initial begin
        int r_low, b_high, st_high, p1_high, g_low, r_low2, r_low3;

        // Rows 0..2: reset with all colours requested; rows 3.. are cycles k = row-3 after release.
        for (int i = 0; i < 47; i++) begin
            int k;
            k = i - 3;
            if (i < 3) begin
                vt[i] = '{rst: 1'b1, r: 1'b1, g: 1'b1, b: 1'b1, pins: 3'b111, st: 1'b1, lr: 8'd0, lb: 8'd0};
            end else begin
                vt[i].rst  = 1'b0;
                vt[i].r    = 1'b1;
                vt[i].g    = 1'b0;
                vt[i].b    = (k >= 24 && k < 32);
                vt[i].pins = 3'b111;
                vt[i].st   = (k < 2) ? 1'b1 : (k < 17) ? 1'b0 : (k < 26) ? 1'b1 : (k < 41) ? 1'b0 : 1'b1;
                vt[i].lr   = (k < 3) ? 8'd0 : (k < 7) ? 8'd64 : (k < 11) ? 8'd128 : (k < 15) ? 8'd192 : 8'd255;
                vt[i].lb   = (k < 27) ? 8'd0 : (k < 31) ? 8'd64 : (k < 35) ? 8'd128 : (k < 39) ? 8'd64 : 8'd0;
            end
        end

        rst2 = 1'b1; red2 = 1'b0; green2 = 1'b0; blue2 = 1'b0;

        for (int i = 0; i < 47; i++) begin
            rst = vt[i].rst; red = vt[i].r; green = vt[i].g; blue = vt[i].b;
            push($sformatf("vec%0d_pins", i),    0, {29'b0, vt[i].pins});
            push($sformatf("vec%0d_settled", i), 1, {31'b0, vt[i].st});
            push($sformatf("vec%0d_level_r", i), 2, {24'b0, vt[i].lr});
            push($sformatf("vec%0d_level_b", i), 3, {24'b0, vt[i].lb});
            step_drain();
        end

        // Red saturated at 255 and blue back at 0: after the first period boundary red is solid on.
        r_low = 0; b_high = 0; st_high = 0;
        for (int k = 44; k <= 300; k++) begin
            @(posedge clk);
            #1;
            if (k == 255) chk("rgb_r_before_boundary", {31'b0, rgb_r}, 32'd1);
            if (k >= 256) begin
                if (!rgb_r)  r_low++;
                if (rgb_b)   b_high++;
                if (settled) st_high++;
            end
        end
        chk("rgb_r_low_cycles_256_300", r_low, 45);
        chk("rgb_b_high_cycles_256_300", b_high, 45);
        chk("settled_high_cycles_256_300", st_high, 45);

        // Reset in the middle of a ramp.
        rst = 1'b1; red = 1'b1; green = 1'b0; blue = 1'b0;
        step_drain();
        push("rst2_pins", 0, 32'd7);
        push("rst2_settled", 1, 32'd1);
        step_drain();
        rst = 1'b0;
        for (int k = 0; k < 12; k++) begin
            if (k == 11) push("midramp_level_r_192", 2, 32'd192);
            step_drain();
        end
        rst = 1'b1;
        push("midrst_pins", 0, 32'd7);
        push("midrst_settled", 1, 32'd1);
        push("midrst_level_r", 2, 32'd0);
        push("midrst_pwm_cnt", 4, 32'd0);
        step_drain();
        rst = 1'b0;
        push("restart_pwm_cnt", 4, 32'd1);
        step_drain();
        step_drain();
        push("restart_level_r_k2", 2, 32'd0);
        step_drain();
        push("restart_level_r_k3", 2, 32'd64);
        step_drain();

        // Slow instance: ticks at k = 356 (pwm_cnt 100) and k = 713 (pwm_cnt 201).
        @(posedge clk);
        @(posedge clk);
        #1;
        rst2 = 1'b0; red2 = 1'b1; green2 = 1'b1; blue2 = 1'b0;
        p1_high = 0; g_low = 0; r_low2 = 0; r_low3 = 0;
        for (int k = 0; k < 1024; k++) begin
            @(posedge clk);
            #1;
            if (k == 355) chk("slow_level_g_k355", {24'b0, dut2.level_q[1]}, 32'd0);
            if (k == 356) chk("slow_level_g_k356", {24'b0, dut2.level_q[1]}, 32'd64);
            if (k == 713) chk("slow_level_r_k713", {24'b0, dut2.level_q[0]}, 32'd128);
            if (k == 511) chk("rgb_g_k511", {31'b0, rgb_g2}, 32'd1);
            if (k == 512) chk("rgb_g_k512", {31'b0, rgb_g2}, 32'd0);
            if (k == 575) chk("rgb_g_k575", {31'b0, rgb_g2}, 32'd0);
            if (k == 576) chk("rgb_g_k576", {31'b0, rgb_g2}, 32'd1);
            if (k >= 256 && k < 512 && rgb_r2)  p1_high++;
            if (k >= 512 && k < 768 && !rgb_g2) g_low++;
            if (k >= 512 && k < 768 && !rgb_r2) r_low2++;
            if (k >= 768 && !rgb_r2)            r_low3++;
        end
        chk("rgb_r_period_with_midchange_high", p1_high, 256);
        chk("rgb_g_duty64_low_cycles", g_low, 64);
        chk("rgb_r_period_with_midchange_low", r_low2, 64);
        chk("rgb_r_duty128_low_cycles", r_low3, 128);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end
endmodule
